// File: rtl/axis_fmcw_rti_v2.sv
// axis_fmcw_rti_v2: combines upbeat/downbeat FFT frames per bin in RAM, streams the range profile and taps STFT bins
module axis_fmcw_rti_v2 #(
    parameter int AXIS_TDATA_WIDTH = 48,
    parameter int AXIS_TUSER_WIDTH = 16,
    parameter int ADDR_WIDTH       = 12,
    parameter int STFT_CHANNELS    = 3
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic [ADDR_WIDTH+9:0]                       cfg_data,
    input  logic [AXIS_TDATA_WIDTH-1:0]                 s_axis_fft_tdata,
    input  logic [AXIS_TUSER_WIDTH-1:0]                 s_axis_fft_tuser,
    input  logic                                        s_axis_fft_tlast,
    input  logic                                        s_axis_fft_tvalid,
    output logic                                        s_axis_fft_tready,
    output logic [AXIS_TDATA_WIDTH-1:0]                 m_axis_avg_tdata,
    output logic [AXIS_TUSER_WIDTH-1:0]                 m_axis_avg_tuser,
    output logic                                        m_axis_avg_tlast,
    output logic                                        m_axis_avg_tvalid,
    input  logic                                        m_axis_avg_tready,
    output logic [AXIS_TDATA_WIDTH*STFT_CHANNELS-1:0]   m_axis_stft_tdata,
    output logic                                        m_axis_stft_tlast,
    output logic                                        m_axis_stft_tvalid,
    input  logic                                        m_axis_stft_tready,
    output logic                                        sts_err,
    output logic                                        sts_stft_drop
);
    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int H  = W / 2;
    localparam int AW = ADDR_WIDTH;
    localparam int CH = STFT_CHANNELS;

    typedef enum logic [1:0] {IDLE, UPBEAT, DOWNBEAT, TRANSFER} state_t;

    state_t          state;
    logic [3:0]      l_r, s_r;
    logic [1:0]      mode_r;
    logic [AW-1:0]   tgt_r;
    logic [AW:0]     cnt, rptr, nb;
    logic [AW-1:0]   mask, s_bin, d_bin, p_bin;
    logic [W-1:0]    mem [2**AW];
    logic [W-1:0]    rd_data, d_data, comb;
    logic [W-1:0]    cap [CH];
    logic [H:0]      sr, si;
    logic [15:0]     scnt, smax;
    logic            d_vld, p_vld, s_acc, avg_acc, adv, issue, load, sweep_end, latch;
    logic            unused_tuser;

    assign nb           = (AW+1)'(1) << l_r;
    assign mask         = nb[AW-1:0] - AW'(1);
    assign smax         = 16'((17'd1 << s_r) - 17'd1);
    assign s_bin        = s_axis_fft_tuser[AW-1:0];
    assign unused_tuser = ^s_axis_fft_tuser;
    assign s_axis_fft_tready = (state == UPBEAT) || (state == DOWNBEAT);
    assign s_acc        = s_axis_fft_tvalid && s_axis_fft_tready;
    assign avg_acc      = m_axis_avg_tvalid && m_axis_avg_tready;
    assign adv          = !m_axis_avg_tvalid || m_axis_avg_tready;
    assign issue        = (state == TRANSFER) && (rptr < nb) && (!p_vld || adv);
    assign load         = p_vld && adv;
    assign sweep_end    = (state == TRANSFER) && avg_acc && m_axis_avg_tlast;
    assign latch        = (state == IDLE) || sweep_end;

    // per-component combine of the stored upbeat with the delayed downbeat, halved with floor
    always_comb begin
        sr   = mode_r[0] ? {rd_data[H-1], rd_data[H-1:0]} - {d_data[H-1], d_data[H-1:0]}
                         : {rd_data[H-1], rd_data[H-1:0]} + {d_data[H-1], d_data[H-1:0]};
        si   = mode_r[0] ? {rd_data[W-1], rd_data[W-1:H]} - {d_data[W-1], d_data[W-1:H]}
                         : {rd_data[W-1], rd_data[W-1:H]} + {d_data[W-1], d_data[W-1:H]};
        comb = (mode_r == 2'd2) ? d_data : {si[H:1], sr[H:1]};
    end

    // bin RAM: upbeat writes, downbeat read-modify-write, transfer reads
    always_ff @(posedge aclk) begin
        if (state == UPBEAT && s_acc)
            mem[s_bin] <= s_axis_fft_tdata;
        else if (d_vld && mode_r != 2'd1)
            mem[d_bin] <= comb;
        if (state == DOWNBEAT && s_acc)
            rd_data <= mem[s_bin];
        else if (issue)
            rd_data <= mem[rptr[AW-1:0]];
    end

    // sweep FSM, beat checking, transfer pipeline and STFT tap
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            l_r                <= '0;
            s_r                <= '0;
            mode_r             <= '0;
            tgt_r              <= '0;
            cnt                <= '0;
            rptr               <= '0;
            p_bin              <= '0;
            p_vld              <= 1'b0;
            d_vld              <= 1'b0;
            d_bin              <= '0;
            d_data             <= '0;
            scnt               <= '0;
            for (int i = 0; i < CH; i++) cap[i] <= '0;
            m_axis_avg_tdata   <= '0;
            m_axis_avg_tuser   <= '0;
            m_axis_avg_tlast   <= 1'b0;
            m_axis_avg_tvalid  <= 1'b0;
            m_axis_stft_tdata  <= '0;
            m_axis_stft_tlast  <= 1'b0;
            m_axis_stft_tvalid <= 1'b0;
            sts_err            <= 1'b0;
            sts_stft_drop      <= 1'b0;
        end else begin
            d_vld  <= (state == DOWNBEAT) && s_acc;
            d_bin  <= s_bin;
            d_data <= s_axis_fft_tdata;
            if (s_acc) begin
                cnt <= s_axis_fft_tlast ? '0 : cnt + 1'b1;
                if (s_axis_fft_tlast && (cnt + 1'b1) != nb) sts_err <= 1'b1;
            end
            if (issue) begin
                rptr  <= rptr + 1'b1;
                p_bin <= rptr[AW-1:0];
                p_vld <= 1'b1;
            end else if (load) begin
                p_vld <= 1'b0;
            end
            if (load) begin
                m_axis_avg_tdata  <= rd_data;
                m_axis_avg_tuser  <= AXIS_TUSER_WIDTH'(p_bin);
                m_axis_avg_tlast  <= (p_bin == mask);
                m_axis_avg_tvalid <= 1'b1;
                for (int i = 0; i < CH; i++)
                    if (p_bin == ((tgt_r + AW'(i)) & mask)) cap[i] <= rd_data;
            end else if (avg_acc) begin
                m_axis_avg_tvalid <= 1'b0;
            end
            if (m_axis_stft_tvalid && m_axis_stft_tready) m_axis_stft_tvalid <= 1'b0;
            if (sweep_end) begin
                for (int i = 0; i < CH; i++) m_axis_stft_tdata[i*W +: W] <= cap[i];
                m_axis_stft_tvalid <= 1'b1;
                m_axis_stft_tlast  <= (scnt == smax);
                scnt               <= (scnt == smax) ? '0 : scnt + 1'b1;
                if (m_axis_stft_tvalid && !m_axis_stft_tready) sts_stft_drop <= 1'b1;
            end
            if (latch) begin
                l_r    <= cfg_data[3:0];
                s_r    <= cfg_data[7:4];
                mode_r <= cfg_data[9:8];
                tgt_r  <= cfg_data[AW+9:10];
            end
            case (state)
                IDLE:     state <= UPBEAT;
                UPBEAT:   if (s_acc && s_axis_fft_tlast) state <= DOWNBEAT;
                DOWNBEAT: if (s_acc && s_axis_fft_tlast) begin
                              state <= TRANSFER;
                              rptr  <= '0;
                          end
                TRANSFER: if (sweep_end) state <= UPBEAT;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_fmcw_rti_v2.sv
// tb_axis_fmcw_rti_v2: randomized sweeps against a per-bin arithmetic model of the range-time block
module tb_axis_fmcw_rti_v2;
    localparam int CW = 22;

    logic          aclk, aresetn;
    logic [CW-1:0] cfg_data;
    logic [47:0]   s_tdata;
    logic [15:0]   s_tuser;
    logic          s_tlast, s_tvalid, s_tready;
    logic [47:0]   m_tdata;
    logic [15:0]   m_tuser;
    logic          m_tlast, m_tvalid, m_tready;
    logic [143:0]  st_tdata;
    logic          st_tlast, st_tvalid, st_tready;
    logic          sts_err, sts_stft_drop;

    axis_fmcw_rti_v2 dut (
        .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data),
        .s_axis_fft_tdata(s_tdata), .s_axis_fft_tuser(s_tuser), .s_axis_fft_tlast(s_tlast),
        .s_axis_fft_tvalid(s_tvalid), .s_axis_fft_tready(s_tready),
        .m_axis_avg_tdata(m_tdata), .m_axis_avg_tuser(m_tuser), .m_axis_avg_tlast(m_tlast),
        .m_axis_avg_tvalid(m_tvalid), .m_axis_avg_tready(m_tready),
        .m_axis_stft_tdata(st_tdata), .m_axis_stft_tlast(st_tlast),
        .m_axis_stft_tvalid(st_tvalid), .m_axis_stft_tready(st_tready),
        .sts_err(sts_err), .sts_stft_drop(sts_stft_drop)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int            total = 0, bad = 0;
    logic [47:0]   up_d [16], dn_d [16], exp_d [16], got_d [16];
    logic [15:0]   got_u [16];
    logic          got_l [16];
    int            got_n, stall_bad, sready_bad, first_idx;
    logic          stft_v, stft_l;
    logic [143:0]  stft_d;
    logic [CW-1:0] lat_cfg;

    function automatic logic [47:0] cplx(input int re, input int im);
        return {im[23:0], re[23:0]};
    endfunction

    function automatic logic [CW-1:0] mk_cfg(input int l, input int s, input int m, input int t);
        return {t[11:0], m[1:0], s[3:0], l[3:0]};
    endfunction

    function automatic logic [47:0] ref_bin(input logic [47:0] u, input logic [47:0] d, input logic [1:0] m);
        int ur, ui, dr, di;
        ur = $signed(u[23:0]);
        ui = $signed(u[47:24]);
        dr = $signed(d[23:0]);
        di = $signed(d[47:24]);
        if (m == 2'd1) return u;
        if (m == 2'd2) return d;
        if (m == 2'd0) return cplx((ur + dr) >>> 1, (ui + di) >>> 1);
        return cplx((ur - dr) >>> 1, (ui - di) >>> 1);
    endfunction

    task automatic rand_data();
        for (int k = 0; k < 16; k++) begin
            up_d[k] = 48'({$urandom(), $urandom()});
            dn_d[k] = 48'({$urandom(), $urandom()});
        end
    endtask

    task automatic do_reset(input logic [CW-1:0] cfg);
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b0;
        cfg_data = cfg;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        lat_cfg = cfg;
    endtask

    task automatic send_beat(input bit dn, input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            int cyc;
            bit acc;
            s_tdata  = dn ? dn_d[i] : up_d[i];
            s_tuser  = 16'(i);
            s_tlast  = with_last && (i == n - 1);
            s_tvalid = 1'b1;
            cyc = 0;
            acc = 0;
            while (!acc && cyc < 64) begin
                @(negedge aclk);
                acc = s_tready;
                @(posedge aclk);
                #1;
                cyc++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL beat_accept bin=%0d: tready=%0b, required 1", i, s_tready);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic run_sweep(input int n_up, input int n_dn, input int pct, input logic [CW-1:0] next_cfg);
        int nb;
        logic hold;
        logic [64:0] prev;
        nb = 1 << lat_cfg[3:0];
        for (int k = 0; k < 16; k++)
            exp_d[k] = (k < n_dn) ? ref_bin(up_d[k], dn_d[k], lat_cfg[9:8]) : up_d[k];
        send_beat(1'b0, n_up, 1'b1);
        send_beat(1'b1, n_dn, 1'b1);
        cfg_data   = next_cfg;
        got_n      = 0;
        stall_bad  = 0;
        sready_bad = 0;
        first_idx  = -1;
        hold       = 1'b0;
        prev       = '0;
        m_tready   = int'($urandom_range(99)) < pct;
        for (int c = 0; c < 400 && got_n < nb; c++) begin
            @(negedge aclk);
            if (m_tvalid && first_idx < 0) first_idx = c;
            if (hold && {m_tdata, m_tuser, m_tlast} !== prev) stall_bad++;
            if (s_tready) sready_bad++;
            hold = m_tvalid && !m_tready;
            prev = {m_tdata, m_tuser, m_tlast};
            if (m_tvalid && m_tready) begin
                got_d[got_n] = m_tdata;
                got_u[got_n] = m_tuser;
                got_l[got_n] = m_tlast;
                got_n++;
            end
            if (got_n < nb) begin
                @(posedge aclk);
                #1;
                m_tready = int'($urandom_range(99)) < pct;
            end
        end
        if (got_n < nb) begin
            total++;
            bad++;
            $display("FAIL transfer_timeout: got %0d bins, required %0d", got_n, nb);
        end
        @(posedge aclk);
        #1;
        m_tready = 1'b0;
        lat_cfg  = next_cfg;
        stft_v   = st_tvalid;
        stft_d   = st_tdata;
        stft_l   = st_tlast;
    endtask

    task automatic test_reset();
        aresetn   = 1'b1;
        cfg_data  = '0;
        s_tdata   = '0;
        s_tuser   = '0;
        s_tlast   = 1'b0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;
        st_tready = 1'b0;
        #1 aresetn = 1'b0;
        #2;
        total++;
        if ({s_tready, m_tdata, m_tuser, m_tlast, m_tvalid, st_tdata, st_tlast, st_tvalid, sts_err, sts_stft_drop} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got tvalid=%0b tready=%0b stft_v=%0b err=%0b, required all 0", m_tvalid, s_tready, st_tvalid, sts_err);
        end
        do_reset(mk_cfg(4, 1, 0, 0));
        total++;
        if (s_tready !== 1'b0) begin
            bad++;
            $display("FAIL idle_tready: got %0b, required 0", s_tready);
        end
        @(negedge aclk);
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL upbeat_entry: tready=%0b, required 1", s_tready);
        end
    endtask

    task automatic test_mode0();
        do_reset(mk_cfg(4, 1, 0, 3));
        st_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            up_d[k] = cplx(2 * k, -2 * k);
            dn_d[k] = cplx(4, 2);
        end
        run_sweep(16, 16, 100, mk_cfg(4, 1, 0, 3));
        for (int k = 0; k < 16; k++) begin
            total++;
            if (got_d[k] !== cplx(k + 2, 1 - k) || got_u[k] !== 16'(k) || got_l[k] !== (k == 15)) begin
                bad++;
                $display("FAIL mode0_bin%0d: got d=%h u=%0d l=%0b, required d=%h u=%0d l=%0b", k, got_d[k], got_u[k], got_l[k], cplx(k + 2, 1 - k), k, k == 15);
            end
        end
        total++;
        if (first_idx !== 2) begin
            bad++;
            $display("FAIL first_latency: got %0d, required 2", first_idx);
        end
        total++;
        if (stft_v !== 1'b1 || stft_l !== 1'b0 || stft_d !== {cplx(7, -4), cplx(6, -3), cplx(5, -2)}) begin
            bad++;
            $display("FAIL mode0_stft: got v=%0b l=%0b d=%h, required v=1 l=0", stft_v, stft_l, stft_d);
        end
        @(posedge aclk);
        #1;
        total++;
        if (st_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL stft_once: tvalid=%0b, required 0", st_tvalid);
        end
    endtask

    task automatic test_modes();
        do_reset(mk_cfg(4, 1, 3, 0));
        st_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            up_d[k] = cplx(-3, -3);
            dn_d[k] = cplx(2, 2);
        end
        run_sweep(16, 16, 100, mk_cfg(4, 1, 1, 0));
        for (int k = 0; k < 16; k++) begin
            total++;
            if (got_d[k] !== cplx(-3, -3) || got_u[k] !== 16'(k)) begin
                bad++;
                $display("FAIL mode3_bin%0d: got %h, required %h", k, got_d[k], cplx(-3, -3));
            end
        end
        rand_data();
        run_sweep(16, 16, 100, mk_cfg(4, 1, 2, 0));
        for (int k = 0; k < 16; k++) begin
            total++;
            if (got_d[k] !== up_d[k] || got_u[k] !== 16'(k)) begin
                bad++;
                $display("FAIL mode1_bin%0d: got %h, required %h", k, got_d[k], up_d[k]);
            end
        end
        rand_data();
        run_sweep(16, 16, 100, mk_cfg(4, 1, 0, 0));
        for (int k = 0; k < 16; k++) begin
            total++;
            if (got_d[k] !== dn_d[k] || got_u[k] !== 16'(k)) begin
                bad++;
                $display("FAIL mode2_bin%0d: got %h, required %h", k, got_d[k], dn_d[k]);
            end
        end
    endtask

    task automatic test_wrap_stft();
        do_reset(mk_cfg(4, 2, 0, 14));
        st_tready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            rand_data();
            run_sweep(16, 16, 100, mk_cfg(4, 2, 0, 14));
            total++;
            if (stft_v !== 1'b1 || stft_d !== {exp_d[0], exp_d[15], exp_d[14]} || stft_l !== ((s % 4) == 3)) begin
                bad++;
                $display("FAIL wrap_stft_sweep%0d: got v=%0b l=%0b d=%h, required v=1 l=%0b d=%h", s + 1, stft_v, stft_l, stft_d, (s % 4) == 3, {exp_d[0], exp_d[15], exp_d[14]});
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [CW-1:0] cur, nxt;
        logic [143:0] es;
        int nb, t;
        cur = mk_cfg(4, 1, int'($urandom_range(3)), int'($urandom_range(15)));
        do_reset(cur);
        st_tready = 1'b1;
        for (int s = 0; s < 5; s++) begin
            nb = 1 << cur[3:0];
            t  = int'(cur[21:10]);
            rand_data();
            nxt = mk_cfg(int'($urandom_range(4, 1)), 1, int'($urandom_range(3)), int'($urandom_range(15)));
            run_sweep(nb, nb, 50, nxt);
            for (int k = 0; k < nb; k++) begin
                total++;
                if (got_d[k] !== exp_d[k] || got_u[k] !== 16'(k) || got_l[k] !== (k == nb - 1)) begin
                    bad++;
                    $display("FAIL bp_s%0d_bin%0d: got d=%h u=%0d l=%0b, required d=%h u=%0d l=%0b", s, k, got_d[k], got_u[k], got_l[k], exp_d[k], k, k == nb - 1);
                end
            end
            total++;
            if (stall_bad !== 0 || sready_bad !== 0) begin
                bad++;
                $display("FAIL bp_stall_s%0d: unstable=%0d s_tready_high=%0d, required 0 and 0", s, stall_bad, sready_bad);
            end
            es = {exp_d[(t + 2) % nb], exp_d[(t + 1) % nb], exp_d[t % nb]};
            total++;
            if (stft_v !== 1'b1 || stft_d !== es || stft_l !== ((s % 2) == 1)) begin
                bad++;
                $display("FAIL bp_stft_s%0d: got v=%0b l=%0b d=%h, required v=1 l=%0b d=%h", s, stft_v, stft_l, stft_d, (s % 2) == 1, es);
            end
            cur = nxt;
        end
        total++;
        if (sts_err !== 1'b0 || sts_stft_drop !== 1'b0) begin
            bad++;
            $display("FAIL bp_status: err=%0b drop=%0b, required 0 and 0", sts_err, sts_stft_drop);
        end
    endtask

    task automatic test_err_drop();
        do_reset(mk_cfg(4, 1, 0, 0));
        st_tready = 1'b0;
        rand_data();
        run_sweep(16, 10, 100, mk_cfg(4, 1, 0, 0));
        total++;
        if (sts_err !== 1'b1 || got_n !== 16) begin
            bad++;
            $display("FAIL short_beat: err=%0b bins=%0d, required err=1 bins=16", sts_err, got_n);
        end
        for (int k = 0; k < 16; k++) begin
            total++;
            if (got_d[k] !== exp_d[k]) begin
                bad++;
                $display("FAIL short_beat_bin%0d: got %h, required %h", k, got_d[k], exp_d[k]);
            end
        end
        total++;
        if (sts_stft_drop !== 1'b0 || stft_v !== 1'b1) begin
            bad++;
            $display("FAIL drop_early: drop=%0b v=%0b, required drop=0 v=1", sts_stft_drop, stft_v);
        end
        rand_data();
        run_sweep(16, 16, 100, mk_cfg(4, 1, 0, 0));
        total++;
        if (sts_stft_drop !== 1'b1 || stft_v !== 1'b1 || stft_l !== 1'b1 || stft_d !== {exp_d[2], exp_d[1], exp_d[0]}) begin
            bad++;
            $display("FAIL stft_drop: drop=%0b v=%0b l=%0b d=%h, required drop=1 v=1 l=1 d=%h", sts_stft_drop, stft_v, stft_l, stft_d, {exp_d[2], exp_d[1], exp_d[0]});
        end
        st_tready = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset(mk_cfg(4, 1, 0, 5));
        st_tready = 1'b0;
        rand_data();
        run_sweep(16, 16, 100, mk_cfg(4, 1, 0, 5));
        rand_data();
        send_beat(1'b0, 16, 1'b1);
        send_beat(1'b1, 8, 1'b0);
        aresetn = 1'b0;
        #1;
        total++;
        if ({s_tready, m_tdata, m_tuser, m_tlast, m_tvalid, st_tdata, st_tlast, st_tvalid, sts_err, sts_stft_drop} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: tready=%0b avg_v=%0b stft_v=%0b avg_d=%h, required all 0", s_tready, m_tvalid, st_tvalid, m_tdata);
        end
        do_reset(mk_cfg(4, 1, 0, 5));
        st_tready = 1'b1;
        rand_data();
        run_sweep(16, 16, 100, mk_cfg(4, 1, 0, 5));
        for (int k = 0; k < 16; k++) begin
            total++;
            if (got_d[k] !== exp_d[k] || got_u[k] !== 16'(k)) begin
                bad++;
                $display("FAIL after_reset_bin%0d: got %h, required %h", k, got_d[k], exp_d[k]);
            end
        end
        total++;
        if (stft_v !== 1'b1 || stft_l !== 1'b0 || stft_d !== {exp_d[7], exp_d[6], exp_d[5]}) begin
            bad++;
            $display("FAIL after_reset_stft: v=%0b l=%0b d=%h, required v=1 l=0 d=%h", stft_v, stft_l, stft_d, {exp_d[7], exp_d[6], exp_d[5]});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_wrap_stft();
        test_back_pressure();
        test_err_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
